btn_debounce: RTL and testbench

Multi-channel push-button debouncer, placed directly upstream of the one-shot edge detector. Raw, bouncing button/switch inputs are synchronised into `clk`. A level change passes to `btn_clean` only after it has held for a programmable number of prescaled ticks. `btn_clean` drives the one-shot `btn` input directly, so each physical press yields exactly one trigger pulse.

---
 rtl/btn_debounce_pkg.sv | 15 +
 rtl/btn_debounce_cell.sv | 53 +++++
 rtl/btn_debounce.sv | 58 +++++
 tb/tb_btn_debounce.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_debounce_pkg : width helper for the debouncer counters                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package btn_debounce_pkg;

    // The counter only has to reach STABLE_TICKS-1. Widening it to hold
    // STABLE_TICKS keeps the width at least 1 bit when STABLE_TICKS is 1.
    function automatic int cnt_width(input int stable_ticks);
        return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_cell : one-channel synchroniser, stability counter, output flop   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module debounce_cell
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_clean
);

    localparam int                c_CNT_W   = cnt_width(STABLE_TICKS);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic               r_s0;
    logic               r_s1;
    logic               r_clean;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_clean <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s0 <= i_raw;
            r_s1 <= r_s0;
            // A single cycle of agreement is treated as a bounce and drops progress.
            if (r_s1 == r_clean) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_clean <= r_s1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign o_clean = r_clean;

endmodule
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_debounce : multi-channel button debouncer with shared tick prescaler   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module btn_debounce #(
    parameter int WIDTH        = 1,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean
);

    logic w_tick;

    generate
        if (TICK_DIV == 1) begin : g_tick_always
            assign w_tick = 1'b1;
        end else begin : g_prescaler
            localparam int              c_PC_W   = $clog2(TICK_DIV);
            localparam logic [c_PC_W-1:0] c_PC_MAX = c_PC_W'(TICK_DIV - 1);
            localparam logic [c_PC_W-1:0] c_PC_ONE = c_PC_W'(1);

            logic [c_PC_W-1:0] r_pc;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pc <= '0;
                end else if (r_pc == c_PC_MAX) begin
                    r_pc <= '0;
                end else begin
                    r_pc <= r_pc + c_PC_ONE;
                end
            end

            assign w_tick = (r_pc == c_PC_MAX);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            debounce_cell #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .i_tick  (w_tick),
                .i_raw   (btn_raw[gi]),
                .o_clean (btn_clean[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_btn_debounce : directed checks, WIDTH=2 TICK_DIV=4 STABLE_TICKS=3       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_btn_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] btn_clean;

    int n_vec = 0;
    int n_err = 0;

    btn_debounce #(
        .WIDTH        (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_vec++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges until btn_clean equals exp (bounded); counts samples that were
    // neither the starting value nor the target.
    task automatic wait_for(input logic [1:0] exp, input int max_edges,
                            output int n, output int n_other);
        logic [1:0] start;
        start   = btn_clean;
        n       = 0;
        n_other = 0;
        while (btn_clean !== exp && n < max_edges) begin
            step(1);
            n++;
            if (btn_clean !== exp && btn_clean !== start) n_other++;
        end
    endtask

    initial begin
        int n;
        int n_other;
        int bad;

        // Reset values and first acceptance at post-reset edge 12.
        rst     = 1'b0;
        btn_raw = 2'b11;
        step(3);
        chk("reset_hold", btn_clean, 2'b00);
        rst = 1'b1;
        step(11);
        chk("accept_e11", btn_clean, 2'b00);
        step(1);
        chk("accept_e12", btn_clean, 2'b11);

        // Release pending (would accept at edge 24); reset just before it.
        btn_raw = 2'b00;
        step(11);
        chk("pending_e23", btn_clean, 2'b11);
        rst = 1'b0;
        #1;
        chk("reset_async", btn_clean, 2'b00);
        btn_raw = 2'b11;
        step(2);
        rst = 1'b1;
        step(11);
        chk("reaccept_e11", btn_clean, 2'b00);
        step(1);
        chk("reaccept_e12", btn_clean, 2'b11);

        btn_raw = 2'b00;
        wait_for(2'b00, 20, n, n_other);
        chk_rng("release_both_lat", n, 11, 14);

        // Clean press and release on channel 0 only.
        btn_raw = 2'b01;
        wait_for(2'b01, 20, n, n_other);
        chk_rng("press0_lat", n, 11, 14);
        step(20);
        chk("press0_hold", btn_clean, 2'b01);
        btn_raw = 2'b00;
        wait_for(2'b00, 20, n, n_other);
        chk_rng("release0_lat", n, 11, 14);

        // Bounce rejection: 3-cycle pulses never get through.
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            btn_raw[0] = ~btn_raw[0];
            for (int c = 0; c < 3; c++) begin
                step(1);
                if (btn_clean !== 2'b00) bad++;
            end
        end
        chk_int("bounce_stable", bad, 0);
        btn_raw = 2'b01;
        wait_for(2'b01, 20, n, n_other);
        chk_rng("after_bounce_lat", n, 11, 14);

        // Glitch at cnt=2 restarts the filter: accept moves from edge 12 to 20.
        rst     = 1'b0;
        btn_raw = 2'b00;
        step(2);
        chk("reset_from_01", btn_clean, 2'b00);
        rst     = 1'b1;
        btn_raw = 2'b01;
        step(8);
        btn_raw = 2'b00;
        step(1);
        btn_raw = 2'b01;
        step(3);
        chk("glitch_e12", btn_clean, 2'b00);
        step(7);
        chk("glitch_e19", btn_clean, 2'b00);
        step(1);
        chk("glitch_e20", btn_clean, 2'b01);

        // Parallel channels: both bits flip on the same edge.
        btn_raw = 2'b10;
        wait_for(2'b10, 20, n, n_other);
        chk_rng("parallel_lat", n, 11, 14);
        chk_int("parallel_same_edge", n_other, 0);
        btn_raw = 2'b00;
        wait_for(2'b00, 20, n, n_other);
        chk_rng("bit1_only_lat", n, 11, 14);
        chk_int("bit1_only_bit0_quiet", n_other, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
